// File: rtl/com_id_sched.sv
// com_id_sched: master-side scheduler for the shared 2-bit com link.
// Arbitrates round-robin among NUM_CH requesters. It serialises the granted
// 4-bit data ID as one frame: a go pulse, two ID symbols and two check symbols.
//
// Ports:
//   sys_clk  system clock, rising edge
//   rst      synchronous active-high reset
//   req      level request per channel, held until that channel's ack
//   id_in    4-bit ID per channel, channel k at [4k+3:4k]
//   ack      one-cycle one-hot pulse, frame for that channel completed
//   rej      one-cycle pulse, granted channel presented ID 0 (no frame sent)
//   cur_ch   latched granted channel
//   busy     high whenever the scheduler is not idle
//   com_go   frame start line
//   com_stb  symbol strobe
//   com_dat  symbol data
module com_id_sched #(
    parameter int NUM_CH = 4,
    parameter int HOLD   = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   req,
    input  logic [4*NUM_CH-1:0] id_in,
    output logic [NUM_CH-1:0]   ack,
    output logic                rej,
    output logic [CH_W-1:0]     cur_ch,
    output logic                busy,
    output logic                com_go,
    output logic                com_stb,
    output logic [1:0]          com_dat
);

    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_GO_HI,
        S_GO_LO,
        S_SYM_SU,
        S_SYM_ST,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sym;
    logic [3:0]       id;
    logic [CH_W-1:0]  ptr;
    logic             rej_q;
    logic             phase_end;
    logic             timed;
    logic             gnt_vld;
    logic [CH_W-1:0]  gnt_ch;
    logic [3:0]       gnt_id;
    logic [CH_W-1:0]  scan_ch;

    function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] ch);
        if (ch == CH_W'(NUM_CH - 1))
            return '0;
        else
            return ch + CH_W'(1);
    endfunction

    // Round-robin scan starting at ptr; first set request wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        scan_ch = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            scan_ch = CH_W'((32'(ptr) + i) % NUM_CH);
            if (!gnt_vld && req[scan_ch]) begin
                gnt_vld = 1'b1;
                gnt_ch  = scan_ch;
            end
        end
        gnt_id = id_in[{gnt_ch, 2'b00} +: 4];
    end

    // State register and datapath registers
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            sym    <= '0;
            id     <= '0;
            cur_ch <= '0;
            ptr    <= '0;
            rej_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            rej_q <= 1'b0;
            if (state_nxt != state)
                cnt <= '0;
            else if (timed)
                cnt <= cnt + CNT_W'(1);
            case (state)
                S_ARB: begin
                    if (gnt_vld) begin
                        cur_ch <= gnt_ch;
                        id     <= gnt_id;
                        if (gnt_id == 4'd0) begin
                            rej_q <= 1'b1;
                            ptr   <= ch_inc(gnt_ch);
                        end
                    end
                end
                S_GO_LO:  if (phase_end) sym <= '0;
                S_SYM_ST: if (phase_end && sym != 2'd3) sym <= sym + 2'd1;
                S_DONE:   ptr <= ch_inc(cur_ch);
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        phase_end = (cnt == CNT_LAST);
        timed     = 1'b0;
        state_nxt = state;
        case (state)
            S_IDLE: if (|req) state_nxt = S_ARB;
            S_ARB: begin
                if (!gnt_vld || gnt_id == 4'd0)
                    state_nxt = S_IDLE;
                else
                    state_nxt = S_GO_HI;
            end
            S_GO_HI: begin
                timed = 1'b1;
                if (phase_end) state_nxt = S_GO_LO;
            end
            S_GO_LO: begin
                timed = 1'b1;
                if (phase_end) state_nxt = S_SYM_SU;
            end
            S_SYM_SU: begin
                timed = 1'b1;
                if (phase_end) state_nxt = S_SYM_ST;
            end
            S_SYM_ST: begin
                timed = 1'b1;
                if (phase_end) state_nxt = (sym == 2'd3) ? S_GAP : S_SYM_SU;
            end
            S_GAP: begin
                timed = 1'b1;
                if (phase_end) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only. rej is held in a register
    // because the ID-0 decision is made from id_in in ARB.
    always_comb begin
        ack     = '0;
        rej     = rej_q;
        busy    = (state != S_IDLE);
        com_go  = (state == S_GO_HI);
        com_stb = (state == S_SYM_ST);
        com_dat = 2'd0;
        if (state == S_SYM_SU || state == S_SYM_ST)
            com_dat = sym[0] ? id[1:0] : id[3:2];
        if (state == S_DONE)
            ack[cur_ch] = 1'b1;
    end

endmodule

// File: tb/tb_com_id_sched.sv
module tb_com_id_sched;

    logic        sys_clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] id_in;
    logic [3:0]  ack;
    logic        rej;
    logic [1:0]  cur_ch;
    logic        busy;
    logic        com_go;
    logic        com_stb;
    logic [1:0]  com_dat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    com_id_sched #(.NUM_CH(4), .HOLD(4)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .req     (req),
        .id_in   (id_in),
        .ack     (ack),
        .rej     (rej),
        .cur_ch  (cur_ch),
        .busy    (busy),
        .com_go  (com_go),
        .com_stb (com_stb),
        .com_dat (com_dat)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    typedef struct {
        int         c;
        logic       go;
        logic       stb;
        logic [1:0] dat;
        logic       bsy;
        logic [3:0] ak;
    } vec_t;

    vec_t tbl[20];

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_id(input int ch, input logic [3:0] v);
        id_in[4*ch +: 4] = v;
    endtask

    // Checks one full frame for channel ch carrying idv. Entered in the IDLE
    // cycle where the request is first visible (k=0); returns at k=47.
    task automatic frame_check(input int ch, input logic [3:0] idv, input int drop_k);
        logic       e_go, e_stb, e_busy;
        logic [1:0] e_dat;
        logic [3:0] e_ack;
        int         s, ph;
        for (int k = 0; k <= 46; k++) begin
            e_go   = (k >= 2 && k <= 5);
            e_busy = (k >= 1);
            e_stb  = 1'b0;
            e_dat  = 2'd0;
            if (k >= 10 && k <= 41) begin
                s     = (k - 10) / 8;
                ph    = (k - 10) % 8;
                e_stb = (ph >= 4);
                e_dat = (s % 2 == 0) ? idv[3:2] : idv[1:0];
            end
            e_ack = (k == 46) ? 4'(1 << ch) : 4'd0;
            check("frm_go",   32'(com_go),  32'(e_go));
            check("frm_stb",  32'(com_stb), 32'(e_stb));
            check("frm_dat",  32'(com_dat), 32'(e_dat));
            check("frm_busy", 32'(busy),    32'(e_busy));
            check("frm_ack",  32'(ack),     32'(e_ack));
            check("frm_rej",  32'(rej),     32'd0);
            if (k >= 2) check("frm_cur_ch", 32'(cur_ch), 32'(ch));
            if (k == drop_k || k == 46) req[ch] = 1'b0;
            step();
        end
        check("frm_end_busy", 32'(busy), 32'd0);
        check("frm_end_ack",  32'(ack),  32'd0);
    endtask

    initial begin
        int c;
        rst   = 1'b1;
        req   = '0;
        id_in = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check("rst_ack",    32'(ack),     32'd0);
        check("rst_rej",    32'(rej),     32'd0);
        check("rst_busy",   32'(busy),    32'd0);
        check("rst_go",     32'(com_go),  32'd0);
        check("rst_stb",    32'(com_stb), 32'd0);
        check("rst_dat",    32'(com_dat), 32'd0);
        check("rst_cur_ch", 32'(cur_ch),  32'd0);
        step();

        // Round robin over all four channels, ids 1..4
        set_id(0, 4'h1); set_id(1, 4'h2); set_id(2, 4'h3); set_id(3, 4'h4);
        req = 4'b1111;
        frame_check(0, 4'h1, -1);
        frame_check(1, 4'h2, -1);
        frame_check(2, 4'h3, -1);
        frame_check(3, 4'h4, -1);
        repeat (3) begin
            check("rr_idle_busy", 32'(busy), 32'd0);
            step();
        end

        // Single frame, id 0xB: symbols 2,3,2,3
        tbl[0]  = '{0,  1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{1,  1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
        tbl[2]  = '{2,  1'b1, 1'b0, 2'd0, 1'b1, 4'b0000};
        tbl[3]  = '{5,  1'b1, 1'b0, 2'd0, 1'b1, 4'b0000};
        tbl[4]  = '{6,  1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
        tbl[5]  = '{9,  1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
        tbl[6]  = '{10, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[7]  = '{13, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[8]  = '{14, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[9]  = '{17, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[10] = '{18, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000};
        tbl[11] = '{22, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000};
        tbl[12] = '{26, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[13] = '{30, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[14] = '{34, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000};
        tbl[15] = '{41, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000};
        tbl[16] = '{42, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
        tbl[17] = '{45, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
        tbl[18] = '{46, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0001};
        tbl[19] = '{47, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        set_id(0, 4'hB);
        req = 4'b0001;
        c   = 0;
        for (int i = 0; i < 20; i++) begin
            while (c < tbl[i].c) begin
                step();
                c++;
            end
            check("tbl_go",   32'(com_go),  32'(tbl[i].go));
            check("tbl_stb",  32'(com_stb), 32'(tbl[i].stb));
            check("tbl_dat",  32'(com_dat), 32'(tbl[i].dat));
            check("tbl_busy", 32'(busy),    32'(tbl[i].bsy));
            check("tbl_ack",  32'(ack),     32'(tbl[i].ak));
            if (c == 46) req[0] = 1'b0;
        end

        // req dropped at cycle 10: frame completes, no second frame
        set_id(0, 4'h6);
        req = 4'b0001;
        frame_check(0, 4'h6, 10);
        repeat (5) begin
            check("drop_busy", 32'(busy),   32'd0);
            check("drop_go",   32'(com_go), 32'd0);
            step();
        end

        // Wrap: ch1 frame leaves ptr=2, then req=0011 grants ch0 first
        set_id(1, 4'h5);
        req = 4'b0010;
        frame_check(1, 4'h5, -1);
        set_id(0, 4'h9);
        req = 4'b0011;
        frame_check(0, 4'h9, -1);
        frame_check(1, 4'h5, -1);

        // ID 0 on ch2: rej pulse, no frame, ptr moves to 3
        set_id(2, 4'h0);
        req = 4'b0100;
        check("rej_c0_busy", 32'(busy), 32'd0);
        step();
        check("rej_c1_busy", 32'(busy), 32'd1);
        check("rej_c1_rej",  32'(rej),  32'd0);
        step();
        check("rej_pulse",  32'(rej),    32'd1);
        check("rej_cur_ch", 32'(cur_ch), 32'd2);
        check("rej_busy",   32'(busy),   32'd0);
        check("rej_go",     32'(com_go), 32'd0);
        check("rej_ack",    32'(ack),    32'd0);
        req = 4'b0000;
        step();
        check("rej_end", 32'(rej), 32'd0);
        repeat (4) begin
            check("rej_after_go",  32'(com_go), 32'd0);
            check("rej_after_ack", 32'(ack),    32'd0);
            check("rej_after_bsy", 32'(busy),   32'd0);
            step();
        end
        set_id(3, 4'hC);
        set_id(1, 4'h3);
        req = 4'b1010;
        frame_check(3, 4'hC, -1);
        frame_check(1, 4'h3, -1);

        // Reset at cycle 20 of a ch0 frame (ptr=2 beforehand)
        set_id(0, 4'hA);
        req = 4'b0001;
        repeat (20) step();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0000;
        check("abort_go",     32'(com_go),  32'd0);
        check("abort_stb",    32'(com_stb), 32'd0);
        check("abort_dat",    32'(com_dat), 32'd0);
        check("abort_busy",   32'(busy),    32'd0);
        check("abort_ack",    32'(ack),     32'd0);
        check("abort_cur_ch", 32'(cur_ch),  32'd0);
        repeat (30) begin
            check("abort_no_ack", 32'(ack),  32'd0);
            check("abort_idle",   32'(busy), 32'd0);
            step();
        end
        // ptr is back to 0, so ch1 wins over ch2
        set_id(1, 4'h7);
        set_id(2, 4'h8);
        req = 4'b0110;
        frame_check(1, 4'h7, -1);
        frame_check(2, 4'h8, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
